// File: rtl/an_encoder_n13.sv
// AN-code (A=13) transmit encoder.
// Forms A*m by sequential shift-add over the bits of A (one bit per cycle),
// then applies an optional XOR fault-injection mask so the downstream
// Barrett-reduction decoder can be exercised with controlled errors.
// One message in flight; valid/ready on both sides.
module an_encoder_n13 #(
  parameter int A     = 13,
  parameter int A_W   = 4,
  parameter int MSG_W = 3,
  parameter int CW_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  input  logic [CW_W-1:0]  in_inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  out_codeword,
  output logic [CW_W-1:0]  out_clean,
  output logic [MSG_W-1:0] out_msg
);

  localparam int              CNT_W  = (A_W > 1) ? $clog2(A_W) : 1;
  localparam logic [A_W-1:0]  A_BITS = A_W'(A);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(A_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW_W-1:0]   acc, acc_sum, mask_r;
  logic [MSG_W-1:0]  m_r;
  logic [CNT_W-1:0]  cnt;
  logic              accept, step, last, out_fire;

  // Ready only in IDLE, and never while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;
  assign last     = (cnt == LAST);

  // Partial product for the current bit of A; CW_W bits suffice for A*max(m).
  assign acc_sum = acc + (A_BITS[cnt] ? (CW_W'(m_r) << cnt) : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    out_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift-add while multiplying, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      m_r          <= '0;
      mask_r       <= '0;
      out_valid    <= 1'b0;
      out_codeword <= '0;
      out_clean    <= '0;
      out_msg      <= '0;
    end else begin
      if (accept) begin
        m_r    <= in_msg;
        mask_r <= in_inj_mask;
        acc    <= '0;
        cnt    <= '0;
      end
      if (step) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          out_clean    <= acc_sum;
          out_codeword <= acc_sum ^ mask_r;
          out_msg      <= m_r;
          out_valid    <= 1'b1;
        end
      end
      // Data outputs keep their last value after the handshake.
      if (out_fire) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_an_encoder_n13.sv
// Self-checking bench for an_encoder_n13: directed vector table, hand-written
// corner sequences (backpressure, back-to-back, reset mid-flight) and random
// transactions compared against an arithmetic reference (A*m ^ mask).
module tb_an_encoder_n13;

  localparam int A = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_msg = '0;
  logic [6:0] in_inj_mask = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] out_codeword, out_clean;
  logic [2:0] out_msg;

  int errors = 0;
  int checks = 0;

  an_encoder_n13 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_msg(in_msg), .in_inj_mask(in_inj_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_clean(out_clean), .out_msg(out_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] msg;
    logic [6:0] mask;
    int         hold;
    logic [6:0] exp_clean;
    logic [6:0] exp_cw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_cw(input logic [2:0] m, input logic [6:0] mask);
    int p;
    p = A * int'(m);
    return 7'(p) ^ mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency, data, optional backpressure, handshake.
  task automatic do_txn(input logic [2:0] m, input logic [6:0] mask, input int hold,
                        input logic [6:0] ec, input logic [6:0] ew, input string tag);
    int  n;
    bit  got;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_msg = m; in_inj_mask = mask; out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    in_msg = 3'($urandom); in_inj_mask = 7'($urandom);
    n = 0; got = 0;
    while (!got && n < 12) begin tick(); n++; got = out_valid; end
    chk({tag, " latency"}, n, 4);
    chk({tag, " clean"}, out_clean, ec);
    chk({tag, " codeword"}, out_codeword, ew);
    chk({tag, " msg"}, out_msg, m);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " held valid"}, out_valid, 1);
      chk({tag, " held cw"}, out_codeword, ew);
      chk({tag, " busy ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " ready back"}, in_ready, 1);
    chk({tag, " data kept"}, out_codeword, ew);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[11];
    int   t1, t2, rises, cyc;
    logic prev;
    logic [6:0] v1, v2;
    logic [2:0] m1, m2;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{msg: 3'(i), mask: 7'd0, hold: 0, exp_clean: 7'(13 * i), exp_cw: 7'(13 * i)};
    vecs[8]  = '{msg: 3'd0, mask: 7'b0000001, hold: 0,  exp_clean: 7'd0,  exp_cw: 7'd1};
    vecs[9]  = '{msg: 3'd2, mask: 7'b0000100, hold: 0,  exp_clean: 7'd26, exp_cw: 7'd30};
    vecs[10] = '{msg: 3'd7, mask: 7'd0,       hold: 10, exp_clean: 7'd91, exp_cw: 7'd91};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst codeword", out_codeword, 0);
    chk("rst clean", out_clean, 0);
    chk("rst msg", out_msg, 0);
    chk("rst in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // Directed table
    foreach (vecs[i])
      do_txn(vecs[i].msg, vecs[i].mask, vecs[i].hold, vecs[i].exp_clean, vecs[i].exp_cw,
             $sformatf("vec%0d", i));

    // Back-to-back with in_valid held: 5 captured, then 3 after the handshake
    in_valid = 1'b1; in_msg = 3'd5; in_inj_mask = 7'd0; out_ready = 1'b1;
    tick();
    in_msg = 3'd3;
    prev = 1'b0; rises = 0; t1 = 0; t2 = 0; v1 = '0; v2 = '0; m1 = '0; m2 = '0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (out_valid && !prev) begin
        rises++;
        if (rises == 1) begin t1 = cyc; v1 = out_codeword; m1 = out_msg; end
        if (rises == 2) begin t2 = cyc; v2 = out_codeword; m2 = out_msg; in_valid = 1'b0; end
      end
      prev = out_valid;
    end
    in_valid = 1'b0;
    chk("b2b rises", rises, 2);
    chk("b2b first cw", v1, 65);
    chk("b2b first msg", m1, 5);
    chk("b2b second cw", v2, 39);
    chk("b2b second msg", m2, 3);
    chk("b2b spacing", t2 - t1, 6);
    chk("b2b first latency", t1, 4);
    out_ready = 1'b0;
    tick(); tick();

    // Reset two edges into MUL discards the message
    in_valid = 1'b1; in_msg = 3'd6; in_inj_mask = 7'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst valid", out_valid, 0);
    chk("midrst cw", out_codeword, 0);
    chk("midrst clean", out_clean, 0);
    chk("midrst ready low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst ready", in_ready, 1);
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); prev = prev | out_valid; end
    chk("midrst no pulse", prev, 0);
    do_txn(3'd1, 7'd0, 0, 7'd13, 7'd13, "after_rst");

    // Reset while waiting in DONE: codeword never handshaken
    in_valid = 1'b1; in_msg = 3'd4; in_inj_mask = 7'd0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("done_rst valid before", out_valid, 1);
    chk("done_rst cw before", out_codeword, 52);
    rst = 1'b1;
    tick();
    chk("done_rst valid", out_valid, 0);
    chk("done_rst cw", out_codeword, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); prev = prev | out_valid; end
    chk("done_rst no pulse", prev, 0);
    out_ready = 1'b0;

    // Random transactions against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      logic [2:0] m;
      logic [6:0] mk;
      int         h;
      m  = 3'($urandom);
      mk = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) mk = 7'($urandom);
      h  = $urandom_range(0, 3);
      do_txn(m, mk, h, ref_cw(m, 7'd0), ref_cw(m, mk), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
